// File: rtl/dma_transfer_engine_if.sv
// Handshake/bus bundle for dma_transfer_engine.
// The master modport is the engine side; the slave modport is the channel logic / bus side.
interface dma_transfer_engine_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8,
   parameter int CNT_W  = 16,
   parameter int NUM_CH = 4
);
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic [NUM_CH-1:0] dack;
   logic              start;
   logic [ADDR_W-1:0] src_addr;
   logic [ADDR_W-1:0] dst_addr;
   logic [CNT_W-1:0]  word_count;
   logic [7:0]        mode;
   logic [7:0]        command;
   logic              eop_in;
   logic [DATA_W-1:0] data_in;
   logic [DATA_W-1:0] data_out;
   logic              data_oe;
   logic [ADDR_W-1:0] addr_out;
   logic [3:0]        control_bus;
   logic [CH_W-1:0]   ch_id;
   logic              busy;
   logic              tc;
   logic              eop;

   modport master (
      input  dack, start, src_addr, dst_addr, word_count, mode, command, eop_in, data_in,
      output data_out, data_oe, addr_out, control_bus, ch_id, busy, tc, eop
   );

   modport slave (
      output dack, start, src_addr, dst_addr, word_count, mode, command, eop_in, data_in,
      input  data_out, data_oe, addr_out, control_bus, ch_id, busy, tc, eop
   );
endinterface

// File: rtl/dma_transfer_engine.sv
// 8237A-style DMA transfer engine: I/O<->memory, verify, and memory-to-memory block transfers.
// Memory-to-memory support (temp register, M_* states) is built only when DMA_MEM2MEM_EN is defined.
module dma_transfer_engine #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8,
   parameter int CNT_W  = 16,
   parameter int NUM_CH = 4
) (
   input logic                   clk,
   input logic                   reset,
   dma_transfer_engine_if.master bus
);
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   typedef enum logic [2:0] {
      IDLE,
      IO_ASSERT,
      IO_NEXT,
`ifdef DMA_MEM2MEM_EN
      M_READ,
      M_LATCH,
      M_WRITE,
      M_NEXT,
`endif
      DONE
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] src_q, src_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              dec_q, dec_d;
   logic [3:0]        io_ctrl_q, io_ctrl_d;
   logic [CH_W-1:0]   ch_q, ch_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [3:0]        ctrl_q, ctrl_d;
   logic              busy_q, busy_d;
   logic              tc_q, tc_d;
   logic              eop_q, eop_d;
`ifdef DMA_MEM2MEM_EN
   logic [ADDR_W-1:0] dst_q, dst_d;
   logic              hold_q, hold_d;
   logic [DATA_W-1:0] temp_q, temp_d;
   logic              oe_q, oe_d;
`endif

   logic dack_ok;
   logic last_word;
   logic exhaust;

   assign dack_ok   = bus.dack[ch_q];
   assign last_word = (cnt_q == '0);
`ifdef DMA_MEM2MEM_EN
   assign exhaust   = dack_ok && last_word && (state_q == IO_NEXT || state_q == M_NEXT);
`else
   assign exhaust   = dack_ok && last_word && (state_q == IO_NEXT);
`endif

   function automatic logic [ADDR_W-1:0] step_addr(input logic [ADDR_W-1:0] a, input logic dec);
      step_addr = dec ? (a - ADDR_W'(1)) : (a + ADDR_W'(1));
   endfunction

   always_comb begin
      state_d   = state_q;
      src_d     = src_q;
      cnt_d     = cnt_q;
      dec_d     = dec_q;
      io_ctrl_d = io_ctrl_q;
      ch_d      = ch_q;
      addr_d    = addr_q;
      ctrl_d    = ctrl_q;
      busy_d    = busy_q;
      tc_d      = 1'b0;
      eop_d     = 1'b0;
`ifdef DMA_MEM2MEM_EN
      dst_d     = dst_q;
      hold_d    = hold_q;
      temp_d    = temp_q;
      oe_d      = oe_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.start && (|bus.dack)) begin
               src_d  = bus.src_addr;
               cnt_d  = bus.word_count;
               dec_d  = bus.mode[5];
               addr_d = bus.src_addr;
               busy_d = 1'b1;
               case (bus.mode[3:2])
                  2'b01:   io_ctrl_d = 4'b0110;
                  2'b10:   io_ctrl_d = 4'b1001;
                  default: io_ctrl_d = 4'b0000;
               endcase
               ch_d = '0;
               for (int unsigned i = NUM_CH; i > 0; i--) begin
                  if (bus.dack[i-1]) ch_d = CH_W'(i - 1);
               end
               state_d = IO_ASSERT;
               ctrl_d  = io_ctrl_d;
`ifdef DMA_MEM2MEM_EN
               dst_d  = bus.dst_addr;
               hold_d = bus.command[1];
               if (bus.command[0]) begin
                  state_d = M_READ;
                  ctrl_d  = 4'b1000;
               end
`endif
            end
         end
         DONE: state_d = IDLE;
         default: begin
            // External EOP wins over everything, including a stalled DACK.
            if (bus.eop_in) begin
               state_d = DONE;
               eop_d   = 1'b1;
               tc_d    = exhaust;
               busy_d  = 1'b0;
               ctrl_d  = '0;
`ifdef DMA_MEM2MEM_EN
               oe_d    = 1'b0;
`endif
            end else if (dack_ok) begin
               case (state_q)
                  IO_ASSERT: begin
                     state_d = IO_NEXT;
                     ctrl_d  = '0;
                  end
                  IO_NEXT: begin
                     src_d = step_addr(src_q, dec_q);
                     cnt_d = cnt_q - CNT_W'(1);
                     if (last_word) begin
                        state_d = DONE;
                        tc_d    = 1'b1;
                        eop_d   = 1'b1;
                        busy_d  = 1'b0;
                     end else begin
                        state_d = IO_ASSERT;
                        addr_d  = step_addr(src_q, dec_q);
                        ctrl_d  = io_ctrl_q;
                     end
                  end
`ifdef DMA_MEM2MEM_EN
                  M_READ: state_d = M_LATCH;
                  M_LATCH: begin
                     state_d = M_WRITE;
                     temp_d  = bus.data_in;
                     addr_d  = dst_q;
                     ctrl_d  = 4'b0100;
                     oe_d    = 1'b1;
                  end
                  M_WRITE: begin
                     state_d = M_NEXT;
                     ctrl_d  = '0;
                     oe_d    = 1'b0;
                  end
                  M_NEXT: begin
                     dst_d = step_addr(dst_q, dec_q);
                     if (!hold_q) src_d = step_addr(src_q, dec_q);
                     cnt_d = cnt_q - CNT_W'(1);
                     if (last_word) begin
                        state_d = DONE;
                        tc_d    = 1'b1;
                        eop_d   = 1'b1;
                        busy_d  = 1'b0;
                     end else begin
                        state_d = M_READ;
                        addr_d  = hold_q ? src_q : step_addr(src_q, dec_q);
                        ctrl_d  = 4'b1000;
                     end
                  end
`endif
                  default: ;
               endcase
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         src_q     <= '0;
         cnt_q     <= '0;
         dec_q     <= 1'b0;
         io_ctrl_q <= '0;
         ch_q      <= '0;
         addr_q    <= '0;
         ctrl_q    <= '0;
         busy_q    <= 1'b0;
         tc_q      <= 1'b0;
         eop_q     <= 1'b0;
`ifdef DMA_MEM2MEM_EN
         dst_q     <= '0;
         hold_q    <= 1'b0;
         temp_q    <= '0;
         oe_q      <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         src_q     <= src_d;
         cnt_q     <= cnt_d;
         dec_q     <= dec_d;
         io_ctrl_q <= io_ctrl_d;
         ch_q      <= ch_d;
         addr_q    <= addr_d;
         ctrl_q    <= ctrl_d;
         busy_q    <= busy_d;
         tc_q      <= tc_d;
         eop_q     <= eop_d;
`ifdef DMA_MEM2MEM_EN
         dst_q     <= dst_d;
         hold_q    <= hold_d;
         temp_q    <= temp_d;
         oe_q      <= oe_d;
`endif
      end
   end

   // Strobes are gated by the live DACK so the bus goes quiet in the same cycle the grant drops.
   assign bus.addr_out    = addr_q;
   assign bus.control_bus = dack_ok ? ctrl_q : '0;
   assign bus.ch_id       = ch_q;
   assign bus.busy        = busy_q;
   assign bus.tc          = tc_q;
   assign bus.eop         = eop_q;

`ifdef DMA_MEM2MEM_EN
   assign bus.data_out = temp_q;
   assign bus.data_oe  = oe_q & dack_ok;

   logic unused_bits;
   assign unused_bits = ^{bus.command[7:2], bus.mode[7:6], bus.mode[4], bus.mode[1:0]};
`else
   assign bus.data_out = '0;
   assign bus.data_oe  = 1'b0;

   logic unused_bits;
   assign unused_bits = ^{bus.command, bus.dst_addr, bus.data_in,
                          bus.mode[7:6], bus.mode[4], bus.mode[1:0]};
`endif
endmodule

// File: tb/tb_dma_transfer_engine.sv
// Directed scoreboard bench for dma_transfer_engine; expected bus cycles are queued before each
// transfer and compared one per cycle at the falling edge.
module tb_dma_transfer_engine;
   localparam int ADDR_W = 16;
   localparam int DATA_W = 8;
   localparam int CNT_W  = 16;
   localparam int NUM_CH = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   dma_transfer_engine_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W), .NUM_CH(NUM_CH)) bus_if ();

   dma_transfer_engine #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W), .NUM_CH(NUM_CH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   typedef struct {
      logic [15:0] addr;
      bit          ca;
      logic [3:0]  ctrl;
      logic [7:0]  dout;
      bit          cd;
      logic        oe;
      logic        tc;
      logic        eop;
      logic        busy;
      logic [1:0]  ch;
      bit          cc;
   } exp_t;

   exp_t        sb[$];
   int unsigned n_assert = 0;
   int unsigned n_fail   = 0;
   string       g_test;
   logic [3:0]  g_dack;
   int          g_drop_from, g_drop_len, g_eop_cyc, g_rst_cyc, g_restart_cyc;
   logic [7:0]  g_d0, g_d1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s.%s: observed %0h expected %0h", g_test, tag, obs, exp);
      end
   endtask

   task automatic push_rec(input logic [15:0] addr, input bit ca, input logic [3:0] ctrl,
                           input logic [7:0] dout, input bit cd, input logic oe, input logic tc,
                           input logic eop, input logic busy, input logic [1:0] ch, input bit cc);
      exp_t e;
      e.addr = addr; e.ca = ca; e.ctrl = ctrl; e.dout = dout; e.cd = cd; e.oe = oe;
      e.tc = tc; e.eop = eop; e.busy = busy; e.ch = ch; e.cc = cc;
      sb.push_back(e);
   endtask

   task automatic push_io_word(input logic [15:0] a, input logic [3:0] ctrl, input logic [1:0] ch);
      push_rec(a, 1, ctrl, 8'h00, 0, 0, 0, 0, 1, ch, 1);
      push_rec(a, 0, 4'b0000, 8'h00, 0, 0, 0, 0, 1, ch, 1);
   endtask

   task automatic push_m2m_word(input logic [15:0] ra, input logic [15:0] wa, input logic [7:0] d,
                                input logic [1:0] ch);
      push_rec(ra, 1, 4'b1000, 8'h00, 0, 0, 0, 0, 1, ch, 1);
      push_rec(ra, 1, 4'b1000, 8'h00, 0, 0, 0, 0, 1, ch, 1);
      push_rec(wa, 1, 4'b0100, d,     1, 1, 0, 0, 1, ch, 1);
      push_rec(wa, 0, 4'b0000, 8'h00, 0, 0, 0, 0, 1, ch, 1);
   endtask

   task automatic push_done(input logic tc);
      push_rec(16'h0, 0, 4'b0000, 8'h00, 0, 0, tc, 1, 0, 2'd0, 0);
   endtask

   task automatic push_idle();
      push_rec(16'h0, 0, 4'b0000, 8'h00, 0, 0, 0, 0, 0, 2'd0, 0);
   endtask

   task automatic push_zero();
      push_rec(16'h0, 1, 4'b0000, 8'h00, 1, 0, 0, 0, 0, 2'd0, 1);
   endtask

   task automatic check_cycle(input int cyc);
      exp_t e;
      e = sb.pop_front();
      chk($sformatf("ctrl@%0d", cyc), 32'(bus_if.control_bus), 32'(e.ctrl));
      chk($sformatf("oe@%0d", cyc),   32'(bus_if.data_oe),     32'(e.oe));
      chk($sformatf("tc@%0d", cyc),   32'(bus_if.tc),          32'(e.tc));
      chk($sformatf("eop@%0d", cyc),  32'(bus_if.eop),         32'(e.eop));
      chk($sformatf("busy@%0d", cyc), 32'(bus_if.busy),        32'(e.busy));
      if (e.ca) chk($sformatf("addr@%0d", cyc), 32'(bus_if.addr_out), 32'(e.addr));
      if (e.cd) chk($sformatf("dout@%0d", cyc), 32'(bus_if.data_out), 32'(e.dout));
      if (e.cc) chk($sformatf("ch@%0d", cyc),   32'(bus_if.ch_id),    32'(e.ch));
   endtask

   task automatic clear_stim();
      g_drop_from = -1; g_drop_len = 0; g_eop_cyc = -1; g_rst_cyc = -1; g_restart_cyc = -1;
      g_d0 = 8'h00; g_d1 = 8'h00;
   endtask

   task automatic start_xfer(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] n,
                             input logic [7:0] mode, input logic [7:0] cmd, input logic [3:0] dackv);
      @(negedge clk);
      bus_if.src_addr   = src;
      bus_if.dst_addr   = dst;
      bus_if.word_count = n;
      bus_if.mode       = mode;
      bus_if.command    = cmd;
      bus_if.dack       = dackv;
      g_dack            = dackv;
      bus_if.start      = 1'b1;
      @(negedge clk);
      bus_if.start      = 1'b0;
   endtask

   // Cycle 1 is the first cycle after the start edge.
   task automatic run();
      int cyc = 1;
      while (sb.size() != 0) begin
         bus_if.dack    = (cyc >= g_drop_from && cyc < g_drop_from + g_drop_len) ? 4'b0000 : g_dack;
         bus_if.eop_in  = (cyc == g_eop_cyc);
         reset          = (cyc == g_rst_cyc);
         bus_if.start   = (cyc == g_restart_cyc);
         bus_if.data_in = (cyc <= 4) ? g_d0 : g_d1;
         #1;
         check_cycle(cyc);
         @(negedge clk);
         cyc++;
      end
      reset         = 1'b0;
      bus_if.start  = 1'b0;
      bus_if.eop_in = 1'b0;
      clear_stim();
   endtask

   initial begin
      reset = 1'b1;
      bus_if.dack = '0; bus_if.start = 1'b0; bus_if.src_addr = '0; bus_if.dst_addr = '0;
      bus_if.word_count = '0; bus_if.mode = '0; bus_if.command = '0; bus_if.eop_in = 1'b0;
      bus_if.data_in = '0;
      g_dack = '0;
      clear_stim();
      repeat (3) @(negedge clk);
      reset = 1'b0;

      g_test = "reset";
      push_zero(); push_zero();
      run();

      g_test = "io2mem";
      push_io_word(16'h12FE, 4'b0110, 2'd0);
      push_io_word(16'h12FF, 4'b0110, 2'd0);
      push_io_word(16'h1300, 4'b0110, 2'd0);
      push_done(1); push_idle();
      start_xfer(16'h12FE, 16'h0000, 16'd2, 8'h04, 8'h00, 4'b0001);
      run();

      g_test = "mem2io_dec";
      g_restart_cyc = 2;
      push_io_word(16'h0001, 4'b1001, 2'd1);
      push_io_word(16'h0000, 4'b1001, 2'd1);
      push_io_word(16'hFFFF, 4'b1001, 2'd1);
      push_done(1); push_idle();
      start_xfer(16'h0001, 16'h0000, 16'd2, 8'h28, 8'h00, 4'b0010);
      run();

      g_test = "verify_illegal";
      push_io_word(16'h55AA, 4'b0000, 2'd3);
      push_io_word(16'h55AB, 4'b0000, 2'd3);
      push_done(1); push_idle();
      start_xfer(16'h55AA, 16'h0000, 16'd1, 8'h0C, 8'h00, 4'b1000);
      run();

      g_test = "start_no_dack";
      push_idle(); push_idle();
      start_xfer(16'h1111, 16'h0000, 16'd3, 8'h04, 8'h00, 4'b0000);
      run();

      g_test = "dack_drop";
      g_drop_from = 3; g_drop_len = 3;
      push_io_word(16'h4000, 4'b0110, 2'd2);
      repeat (3) push_rec(16'h4001, 1, 4'b0000, 8'h00, 0, 0, 0, 0, 1, 2'd2, 1);
      push_io_word(16'h4001, 4'b0110, 2'd2);
      push_done(1); push_idle();
      start_xfer(16'h4000, 16'h0000, 16'd1, 8'h04, 8'h00, 4'b0100);
      run();

      g_test = "eop_in";
      g_eop_cyc = 3;
      push_io_word(16'h0800, 4'b0110, 2'd0);
      push_rec(16'h0801, 1, 4'b0110, 8'h00, 0, 0, 0, 0, 1, 2'd0, 1);
      push_done(0); push_idle();
      start_xfer(16'h0800, 16'h0000, 16'd5, 8'h04, 8'h00, 4'b0001);
      run();

      g_test = "after_eop";
      push_io_word(16'h0900, 4'b1001, 2'd0);
      push_done(1); push_idle();
      start_xfer(16'h0900, 16'h0000, 16'd0, 8'h08, 8'h00, 4'b0001);
      run();

      g_test = "eop_with_tc";
      g_eop_cyc = 2;
      push_io_word(16'h3000, 4'b0110, 2'd0);
      push_done(1); push_idle();
      start_xfer(16'h3000, 16'h0000, 16'd0, 8'h04, 8'h00, 4'b0001);
      run();

`ifdef DMA_MEM2MEM_EN
      g_test = "m2m";
      g_d0 = 8'hA5; g_d1 = 8'h3C;
      push_m2m_word(16'h0100, 16'h0200, 8'hA5, 2'd1);
      push_m2m_word(16'h0101, 16'h0201, 8'h3C, 2'd1);
      push_done(1); push_idle();
      start_xfer(16'h0100, 16'h0200, 16'd1, 8'h00, 8'h01, 4'b0010);
      run();

      g_test = "m2m_hold";
      g_d0 = 8'hA5; g_d1 = 8'h3C;
      push_m2m_word(16'h0100, 16'h0200, 8'hA5, 2'd1);
      push_m2m_word(16'h0100, 16'h0201, 8'h3C, 2'd1);
      push_done(1); push_idle();
      start_xfer(16'h0100, 16'h0200, 16'd1, 8'h00, 8'h03, 4'b0010);
      run();

      g_test = "reset_mid_write";
      g_d0 = 8'hA5; g_rst_cyc = 3;
      push_rec(16'h0100, 1, 4'b1000, 8'h00, 0, 0, 0, 0, 1, 2'd2, 1);
      push_rec(16'h0100, 1, 4'b1000, 8'h00, 0, 0, 0, 0, 1, 2'd2, 1);
      push_rec(16'h0200, 1, 4'b0100, 8'hA5, 1, 1, 0, 0, 1, 2'd2, 1);
      push_zero(); push_zero();
      start_xfer(16'h0100, 16'h0200, 16'd1, 8'h00, 8'h01, 4'b0100);
      run();
`else
      g_test = "cmd_ignored";
      push_io_word(16'h2000, 4'b0110, 2'd1);
      push_io_word(16'h2001, 4'b0110, 2'd1);
      push_done(1); push_idle();
      start_xfer(16'h2000, 16'h3000, 16'd1, 8'h04, 8'h03, 4'b0010);
      run();

      g_test = "reset_mid_xfer";
      g_rst_cyc = 3;
      push_io_word(16'h7000, 4'b1001, 2'd2);
      push_rec(16'h7001, 1, 4'b1001, 8'h00, 0, 0, 0, 0, 1, 2'd2, 1);
      push_zero(); push_zero();
      start_xfer(16'h7000, 16'h0000, 16'd3, 8'h08, 8'h00, 4'b0100);
      run();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/dma_transfer_engine.md
# dma_transfer_engine

Parametrised transfer engine for the 8237A-style DMA controller. It sits between the channel priority/DACK logic and the system bus. Once a channel is granted, it sequences I/O-to-memory, memory-to-I/O, verify, and optional memory-to-memory transfers over a block of N+1 words. It owns the current address and word counters, drives full-width addresses and MEMR/MEMW/IOR/IOW strobes, and reports TC/EOP.

## Interface
- ADDR_W, 16, address width
- DATA_W, 8, data width
- CNT_W, 16, word-count width
- NUM_CH, 4, number of DACK lines; CH_W = max(1, clog2(NUM_CH)) is a localparam
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- dack  in  NUM_CH  one-hot grant; transfer proceeds only while a bit is set
- start  in  1  one-cycle pulse; latches addresses, count, mode, command and channel
- src_addr  in  ADDR_W  start/source address
- dst_addr  in  ADDR_W  mem-to-mem destination address
- word_count  in  CNT_W  N, where N+1 words are transferred
- mode  in  8  [3:2] 01 = I/O→mem, 10 = mem→I/O, 00 = verify, 11 = illegal (treated as verify); [5] address decrement
- command  in  8  [0] mem-to-mem enable; [1] source address hold
- eop_in  in  1  external end-of-process, active-high
- data_in  in  DATA_W  memory read data
- data_out  out  DATA_W  write data (mem-to-mem only)
- data_oe  out  1  data_out valid/drive
- addr_out  out  ADDR_W  bus address
- control_bus  out  4  {MEMR, MEMW, IOR, IOW}, active-high
- ch_id  out  CH_W  index of the dack bit latched at start
- busy  out  1  transfer in progress
- tc  out  1  one-cycle pulse on count exhaustion
- eop  out  1  one-cycle pulse at any termination

## Operation
- States: IDLE, IO_ASSERT, IO_NEXT, M_READ, M_LATCH, M_WRITE, M_NEXT, DONE.
- IDLE: `start` with any dack bit set latches all inputs, sets `busy`, and goes to IO_ASSERT. If mem-to-mem is enabled (command[0] set), it goes to M_READ instead. `start` without dack, or while `busy`, is ignored.
- IO_ASSERT:
  - addr_out = current address.
  - control_bus = 0110 for I/O→mem, 1001 for mem→I/O, 0000 for verify.
- IO_NEXT:
  - control_bus = 0000.
  - Address steps ±1 per mode[5], modulo 2^ADDR_W.
  - Count decrements; if the count was 0 before the decrement, go to DONE with TC.
  - Otherwise return to IO_ASSERT.
- M_READ: addr_out = source address, control_bus = 1000.
- M_LATCH: MEMR stays asserted; the temp register captures data_in at the end of this cycle.
- M_WRITE: addr_out = destination address, control_bus = 0100, data_out = temp, data_oe = 1.
- M_NEXT:
  - control 0000, data_oe 0.
  - Destination address steps ±1; source address steps ±1 unless command[1] (hold) is set.
  - Count and TC logic are as in IO_NEXT; otherwise return to M_READ.
- DONE: asserts `eop` (and `tc` if count-terminated) for one cycle, clears `busy`, returns to IDLE.
- DACK drop: any state other than IDLE/DONE freezes, with control_bus = 0000 and data_oe = 0. Counters hold; the state resumes unchanged when dack returns.
- eop_in while busy: the next cycle enters DONE, with control 0000 and tc = 0. Counters keep their last values. eop_in has priority over a simultaneous TC, but tc still pulses if that cycle also exhausted the count.
- Counter and address arithmetic is unsigned and wraps silently.

## Timing
- Reset: state IDLE; all outputs 0, including data_out, addr_out, ch_id, tc, eop and busy.
- Registered outputs; `start` at edge k puts the first strobe at cycle k+1.
- I/O and verify: 2 cycles per word, so (N+1)×2 cycles plus 1 DONE cycle.
- Mem-to-mem: 4 cycles per word, so (N+1)×4 + 1.
- `tc` and `eop` are coincident in DONE and assert exactly one cycle after the final NEXT state.

## Configuration
- `DMA_MEM2MEM_EN` defined:
  - M_* states and the temp register are present.
  - command[0] selects mem-to-mem and command[1] selects source hold.
- Not defined:
  - command[0] and command[1] are ignored; mode[3:2] governs all transfers.
  - data_out is tied to 0 and data_oe to 0.

## Test plan
- I/O→mem: src 0x12FE, N = 2, inc → addr_out 0x12FE, 0x12FF, 0x1300 with control 0110; tc and eop pulse at cycle 7.
- Mem→I/O, decrement: src 0x0001, N = 2 → addresses 0x0001, 0x0000, 0xFFFF with control 1001; wrap is correct.
- Mem-to-mem (macro on): src 0x0100, dst 0x0200, N = 1, data_in 0xA5 then 0x3C → MEMW at 0x0200 with 0xA5, then 0x0201 with 0x3C; done at cycle 9. With hold set, both reads come from 0x0100.
- DACK dropped for 3 cycles mid-IO_ASSERT → control 0000 while low; transfer resumes at the same address; total length grows by 3.
- eop_in at the second word, N = 5 → DONE next cycle with eop = 1, tc = 0, busy falls; the following `start` runs normally.
- reset asserted mid-M_WRITE → the next cycle has all outputs 0 and state IDLE; macro off with command[0] = 1 → behaves as mode[3:2] I/O transfer.
